tdm_mux_8x1: RTL and testbench

TDM_MUX_8X1 -- requirements
Module: tdm_mux_8x1

---
 rtl/tdm_mux_8x1.sv | 181 ++++++++++++++++++
 tb/tb_tdm_mux_8x1.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_8x1.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_mux_8x1
//  Description : 8-to-1 time-division multiplexer. On a frame request it
//                snapshots eight data bits and eight slot enables, then emits
//                the enabled slots in ascending order, one per clock, with no
//                gap cycles for disabled slots. The slot index is output so a
//                far-end 1x8 demux can steer each bit.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CONT   1 = re-capture d/m after the last slot and keep framing,
//           0 = one frame per start request
//  Ports
//    clk          in   rising-edge clock
//    rst          in   asynchronous active-high reset
//    d7..d0       in   channel data, slot k carries dk
//    m7..m0       in   slot enables, slot k sent only when mk=1
//    start        in   frame request, honoured in IDLE only
//    abort        in   synchronous frame cancel
//    out          out  serialized data bit
//    s2,s1,s0     out  current slot index (s2 is MSB)
//    valid        out  out/s2..s0 carry a live slot this cycle
//    busy         out  frame in progress
//    done         out  one-cycle pulse with the last slot of a frame
// ============================================================================
module tdm_mux_8x1 #(
   parameter bit CONT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d7, input logic d6, input logic d5, input logic d4,
   input  logic d3, input logic d2, input logic d1, input logic d0,
   input  logic m7, input logic m6, input logic m5, input logic m4,
   input  logic m3, input logic m2, input logic m1, input logic m0,
   input  logic start,
   input  logic abort,
   output logic out,
   output logic s2,
   output logic s1,
   output logic s0,
   output logic valid,
   output logic busy,
   output logic done
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   // Index of the lowest set bit (0 when the mask is empty).
   function automatic logic [2:0] lowest_set(input logic [7:0] msk);
      lowest_set = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (msk[i]) lowest_set = 3'(i);
      end
   endfunction

   // The part of msk strictly above slot k.
   function automatic logic [7:0] bits_above(input logic [7:0] msk, input logic [2:0] k);
      bits_above = 8'd0;
      for (int i = 0; i < 8; i++) begin
         if (i > int'(k)) bits_above[i] = msk[i];
      end
   endfunction

   logic [0:0] r_state;
   logic [7:0] r_snap_d;
   logic [7:0] r_snap_m;
   logic [2:0] r_slot;
   logic       r_out;
   logic       r_valid;
   logic       r_done;

   logic [7:0] w_live_d;
   logic [7:0] w_live_m;
   logic [2:0] w_first;
   logic       w_first_last;
   logic [7:0] w_rest;
   logic [2:0] w_next;
   logic       w_next_last;

   logic [0:0] w_state_n;
   logic [7:0] w_snap_d_n;
   logic [7:0] w_snap_m_n;
   logic [2:0] w_slot_n;
   logic       w_out_n;
   logic       w_valid_n;
   logic       w_done_n;

   assign w_live_d = {d7, d6, d5, d4, d3, d2, d1, d0};
   assign w_live_m = {m7, m6, m5, m4, m3, m2, m1, m0};

   // First slot of a fresh capture, and whether it is also the last one.
   assign w_first      = lowest_set(w_live_m);
   assign w_first_last = (bits_above(w_live_m, w_first) == 8'd0);

   // Next slot of the running frame; w_rest empty means the current slot
   // is the final one.
   assign w_rest      = bits_above(r_snap_m, r_slot);
   assign w_next      = lowest_set(w_rest);
   assign w_next_last = (bits_above(r_snap_m, w_next) == 8'd0);

   always_comb begin
      // Default: idle outputs with the snapshot cleared.
      w_state_n  = IDLE;
      w_snap_d_n = 8'd0;
      w_snap_m_n = 8'd0;
      w_slot_n   = 3'd0;
      w_out_n    = 1'b0;
      w_valid_n  = 1'b0;
      w_done_n   = 1'b0;

      case (r_state)
         IDLE: begin
            // abort outranks start even while idle
            if (!abort && start && (w_live_m != 8'd0)) begin
               w_state_n  = SEND;
               w_snap_d_n = w_live_d;
               w_snap_m_n = w_live_m;
               w_slot_n   = w_first;
               w_out_n    = w_live_d[w_first];
               w_valid_n  = 1'b1;
               w_done_n   = w_first_last;
            end
         end
         SEND: begin
            if (abort) begin
               w_state_n = IDLE;
            end else if (w_rest != 8'd0) begin
               w_state_n  = SEND;
               w_snap_d_n = r_snap_d;
               w_snap_m_n = r_snap_m;
               w_slot_n   = w_next;
               w_out_n    = r_snap_d[w_next];
               w_valid_n  = 1'b1;
               w_done_n   = w_next_last;
            end else if (CONT && (w_live_m != 8'd0)) begin
               // Back-to-back frame: fresh snapshot, no idle cycle.
               w_state_n  = SEND;
               w_snap_d_n = w_live_d;
               w_snap_m_n = w_live_m;
               w_slot_n   = w_first;
               w_out_n    = w_live_d[w_first];
               w_valid_n  = 1'b1;
               w_done_n   = w_first_last;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_snap_d <= 8'd0;
         r_snap_m <= 8'd0;
         r_slot   <= 3'd0;
         r_out    <= 1'b0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_snap_d <= w_snap_d_n;
         r_snap_m <= w_snap_m_n;
         r_slot   <= w_slot_n;
         r_out    <= w_out_n;
         r_valid  <= w_valid_n;
         r_done   <= w_done_n;
      end
   end

   assign out   = r_out;
   assign s2    = r_slot[2];
   assign s1    = r_slot[1];
   assign s0    = r_slot[0];
   assign valid = r_valid;
   assign busy  = (r_state == SEND);
   assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tdm_mux_8x1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_mux_8x1
//  Description : Scoreboard bench for tdm_mux_8x1. One instance runs with
//                CONT=0 and one with CONT=1; they share clock, reset, data,
//                mask and abort, and each has its own start and its own
//                expected-slot queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tdm_mux_8x1;

   typedef struct {
      logic       o;
      logic [2:0] s;
      logic       dn;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] d = 8'd0;
   logic [7:0] m = 8'd0;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic       abort = 1'b0;

   logic out0, s20, s10, s00, valid0, busy0, done0;
   logic out1, s21, s11, s01, valid1, busy1, done1;

   exp_t q0[$];
   exp_t q1[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   tdm_mux_8x1 #(.CONT(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .d7(d[7]), .d6(d[6]), .d5(d[5]), .d4(d[4]),
      .d3(d[3]), .d2(d[2]), .d1(d[1]), .d0(d[0]),
      .m7(m[7]), .m6(m[6]), .m5(m[5]), .m4(m[4]),
      .m3(m[3]), .m2(m[2]), .m1(m[1]), .m0(m[0]),
      .start(start0), .abort(abort),
      .out(out0), .s2(s20), .s1(s10), .s0(s00),
      .valid(valid0), .busy(busy0), .done(done0)
   );

   tdm_mux_8x1 #(.CONT(1'b1)) dut1 (
      .clk(clk), .rst(rst),
      .d7(d[7]), .d6(d[6]), .d5(d[5]), .d4(d[4]),
      .d3(d[3]), .d2(d[2]), .d1(d[1]), .d0(d[0]),
      .m7(m[7]), .m6(m[6]), .m5(m[5]), .m4(m[4]),
      .m3(m[3]), .m2(m[2]), .m1(m[1]), .m0(m[0]),
      .start(start1), .abort(abort),
      .out(out1), .s2(s21), .s1(s11), .s0(s01),
      .valid(valid1), .busy(busy1), .done(done1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a frame is simply every enabled slot in ascending
   // order, carrying the captured data bit; the highest one carries done.
   task automatic push_frame(input logic [7:0] dv, input logic [7:0] mv, input bit which);
      exp_t e;
      int   hi = -1;
      for (int k = 0; k < 8; k++) if (mv[k]) hi = k;
      for (int k = 0; k < 8; k++) begin
         if (mv[k]) begin
            e.o  = dv[k];
            e.s  = 3'(k);
            e.dn = (k == hi);
            if (which) q1.push_back(e); else q0.push_back(e);
         end
      end
   endtask

   // Monitors: pop on every valid cycle; outside valid cycles every output
   // must sit at its idle value.
   always @(negedge clk) begin
      exp_t e;
      if (valid0) begin
         if (q0.size() == 0) begin
            check("dut0_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = q0.pop_front();
            check("dut0_slot", {s20, s10, s00}, e.s);
            check("dut0_out",  out0, e.o);
            check("dut0_done", done0, e.dn);
            check("dut0_busy", busy0, 1);
         end
      end else begin
         check("dut0_idle_outputs", {out0, s20, s10, s00, busy0, done0}, 0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (valid1) begin
         if (q1.size() == 0) begin
            check("dut1_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            check("dut1_slot", {s21, s11, s01}, e.s);
            check("dut1_out",  out1, e.o);
            check("dut1_done", done1, e.dn);
            check("dut1_busy", busy1, 1);
         end
      end else begin
         check("dut1_idle_outputs", {out1, s21, s11, s01, busy1, done1}, 0);
      end
   end

   // One CONT=0 frame. mode 0: inputs steady, 1: random d/m/start churn
   // during the frame, 2: d forced to 00 after capture.
   task automatic run_frame(input logic [7:0] dv, input logic [7:0] mv, input int mode);
      int cnt = 0;
      @(posedge clk); #1;
      d = dv; m = mv; start0 = 1'b1;
      push_frame(dv, mv, 1'b0);
      @(posedge clk); #1;
      start0 = 1'b0;
      if (mode == 2) d = 8'h00;
      while (busy0 && cnt < 20) begin
         cnt++;
         if (mode == 1) begin
            d = 8'($urandom);
            m = 8'($urandom);
            start0 = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
      end
      start0 = 1'b0;
      check("frame_length", cnt, $countones(mv));
      check("frame_queue_drained", q0.size(), 0);
   endtask

   initial begin
      logic [7:0] rd, rm;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_dut0", {out0, s20, s10, s00, valid0, busy0, done0}, 0);
      check("reset_dut1", {out1, s21, s11, s01, valid1, busy1, done1}, 0);
      rst = 1'b0;

      // Full mask, alternating pattern
      run_frame(8'hA5, 8'hFF, 0);
      // Slots 0 and 7 only, data dropped to 00 mid-frame
      run_frame(8'hFF, 8'h81, 2);
      // Single slot
      run_frame(8'h10, 8'h10, 0);

      // Empty mask with start held: nothing happens
      @(posedge clk); #1;
      m = 8'h00; d = 8'hFF; start0 = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("empty_mask_idle", {valid0, busy0, done0}, 0);
      end
      start0 = 1'b0;

      // abort in IDLE outranks start
      m = 8'hFF; abort = 1'b1; start0 = 1'b1;
      @(posedge clk); #1;
      check("abort_beats_start", {valid0, busy0}, 0);
      abort = 1'b0; start0 = 1'b0;

      // Abort after the third valid cycle
      @(posedge clk); #1;
      d = 8'h3C; m = 8'hFF; start0 = 1'b1;
      push_frame(8'h3C, 8'hFF, 1'b0);
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_outputs", {valid0, busy0, done0}, 0);
      check("abort_remaining_slots", q0.size(), 5);
      q0.delete();
      run_frame(8'hC3, 8'hFF, 0);

      // Asynchronous reset during slot 4
      @(posedge clk); #1;
      d = 8'hFF; m = 8'hFF; start0 = 1'b1;
      push_frame(8'hFF, 8'hFF, 1'b0);
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("pre_reset_slot4", {valid0, s20, s10, s00}, 4'b1100);
      #1 rst = 1'b1;
      #1;
      check("async_reset_outputs", {out0, s20, s10, s00, valid0, busy0, done0}, 0);
      q0.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("post_reset_idle", {valid0, busy0}, 0);
      end

      // Continuous framing: FF/FF, then data 00, then mask 0 ends it
      @(posedge clk); #1;
      d = 8'hFF; m = 8'hFF; start1 = 1'b1;
      push_frame(8'hFF, 8'hFF, 1'b1);
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("cont_first_done", done1, 1);
      d = 8'h00;
      push_frame(8'h00, 8'hFF, 1'b1);
      @(posedge clk); #1;
      check("cont_no_gap", {valid1, s21, s11, s01}, 4'b1000);
      m = 8'h00;
      repeat (7) @(posedge clk);
      #1;
      check("cont_second_done", done1, 1);
      @(posedge clk); #1;
      check("cont_stop_on_empty_mask", {valid1, busy1}, 0);
      check("cont_queue_drained", q1.size(), 0);

      // Randomized frames with input churn during the frame
      for (int i = 0; i < 30; i++) begin
         rd = 8'($urandom);
         rm = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rm = 8'd1 << $urandom_range(0, 7);
         if ($urandom_range(0, 9) == 0) rm = 8'h00;
         run_frame(rd, rm, 1);
      end

      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
